// File: rtl/seq_divider.sv
// Multi-cycle unsigned divider: one non-restoring add/subtract step per clock
// on a single WIDTH+1-bit add/sub datapath, with a start/busy/done handshake.
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [WIDTH:0]     p_r;
    logic [WIDTH-1:0]   q_r;
    logic [WIDTH-1:0]   d_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   quotient_r;
    logic [WIDTH-1:0]   remainder_r;
    logic               dbz_r;

    logic               accept_s;
    logic               zero_div_s;
    logic               sub_s;
    logic [WIDTH:0]     add_a_s;
    logic [WIDTH:0]     add_b_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     fix_p_s;

    assign accept_s   = start && ((state_r == S_IDLE) || (state_r == S_DONE));
    assign zero_div_s = (divisor == {WIDTH{1'b0}});

    // Shared add/sub operand selection: shifted remainder in CALC, raw remainder in FIX
    always_comb begin
        add_a_s = p_r;
        sub_s   = 1'b0;
        if (state_r == S_CALC) begin
            add_a_s = {p_r[WIDTH-1:0], q_r[WIDTH-1]};
            sub_s   = ~p_r[WIDTH];
        end else begin
            add_a_s = p_r;
            sub_s   = 1'b0;
        end
    end

    // Subtraction is addition of the inverted divisor with carry-in of one
    assign add_b_s = sub_s ? ~{1'b0, d_r} : {1'b0, d_r};
    assign sum_s   = add_a_s + add_b_s + {{WIDTH{1'b0}}, sub_s};
    assign fix_p_s = p_r[WIDTH] ? sum_s : p_r;

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_next_s = zero_div_s ? S_DONE : S_CALC;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_CALC: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_next_s = S_FIX;
                end else begin
                    state_next_s = S_CALC;
                end
            end
            S_FIX: begin
                state_next_s = S_DONE;
            end
            S_DONE: begin
                if (accept_s) begin
                    state_next_s = zero_div_s ? S_DONE : S_CALC;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // State register and handshake outputs, registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == S_CALC) || (state_next_s == S_FIX);
            done_r  <= (state_next_s == S_DONE);
        end
    end

    // Datapath: operand capture, iteration, final correction and result load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_r         <= {(WIDTH+1){1'b0}};
            q_r         <= {WIDTH{1'b0}};
            d_r         <= {WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            dbz_r       <= 1'b0;
        end else begin
            if (accept_s) begin
                p_r   <= {(WIDTH+1){1'b0}};
                q_r   <= dividend;
                d_r   <= divisor;
                cnt_r <= CNT_W'(WIDTH - 1);
                dbz_r <= zero_div_s;
                if (zero_div_s) begin
                    quotient_r  <= {WIDTH{1'b1}};
                    remainder_r <= dividend;
                end else begin
                    quotient_r  <= quotient_r;
                    remainder_r <= remainder_r;
                end
            end else if (state_r == S_CALC) begin
                p_r   <= sum_s;
                q_r   <= {q_r[WIDTH-2:0], ~sum_s[WIDTH]};
                cnt_r <= cnt_r - CNT_W'(1);
            end else if (state_r == S_FIX) begin
                p_r         <= fix_p_s;
                quotient_r  <= q_r;
                remainder_r <= fix_p_s[WIDTH-1:0];
            end else begin
                p_r <= p_r;
            end
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;

endmodule
